controlador_acesso: RTL and testbench
=====================================

CONTROLADOR_ACESSO -- requirements
Module: controlador_acesso

Interface
REQ-001 SHALL have parameter OPEN_CYCLES, default 8, number of cycles porta_aberta stays high per grant (range 1..255).
REQ-002 SHALL have parameter LOCK_CYCLES, default 16, number of cycles of lockout after MAX_TRIES failures (range 1..255).
REQ-003 SHALL have parameter MAX_TRIES, default 3, number of consecutive denials that trigger lockout (range 1..3).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  comparator result presented for evaluation.
REQ-007 SHALL have port aut1, aut2, aut3  input  1 each  authentication lines from the upstream comparator.
REQ-008 SHALL have port req_ready  output  1  controller can accept a request.
REQ-009 SHALL have port porta_aberta  output  1  door unlock drive.
REQ-010 SHALL have port nivel  output  2  level of current grant: 0 none, 1 aut1, 2 aut2, 3 aut3.
REQ-011 SHALL have port tentativas  output  2  consecutive-denial count.
REQ-012 SHALL have ports bloqueado and alarme  output  1 each  lockout active / alarm latched.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, DENY, LOCK.
REQ-014 SHALL drive req_ready high only in IDLE; a request is accepted on a rising edge with req_valid and req_ready both high.
REQ-015 SHALL resolve simultaneous aut lines by priority aut3 > aut2 > aut1; accepted request with any line high -> GRANT, none high -> DENY.
REQ-016 SHALL, on GRANT entry (cycle after accept), assert porta_aberta, load nivel, clear tentativas, and hold for exactly OPEN_CYCLES cycles, then return to IDLE with porta_aberta low and nivel 0.
REQ-017 SHALL, on DENY, increment tentativas (saturating at 3) for one cycle, then go to LOCK if new count equals MAX_TRIES, else IDLE.
REQ-018 SHALL, in LOCK, assert bloqueado for exactly LOCK_CYCLES cycles, ignore req_valid, then clear tentativas and return to IDLE.
REQ-019 SHALL ignore aut lines whenever no request is accepted; req_valid held high re-requests on each IDLE cycle.
REQ-020 SHALL never assert porta_aberta and bloqueado simultaneously.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-GRANT or mid-LOCK, immediately force IDLE, porta_aberta 0, nivel 0, tentativas 0, bloqueado 0, alarme 0, timer 0; req_ready 1 after release.

Configuration
REQ-022 SHALL, with CONTROLADOR_ACESSO_ALARME_EN defined, set alarme on every LOCK entry and hold it until reset; without it, alarme SHALL be constant 0 and no alarm flop SHALL exist.

Structure
REQ-023 SHALL place the FSM state encoding and nivel constants (NIVEL_NENHUM..NIVEL_AUT3) in package controlador_acesso_pkg.
REQ-024 SHALL use one sub-module temporizador: 8-bit loadable down-counter with load, value, and done (count reaches 1) outputs, shared by GRANT and LOCK.

Verification
REQ-025 SHALL cover: accept with aut2=1 -> next cycle porta_aberta=1, nivel=2 for 8 cycles, then IDLE, req_ready=1.
REQ-026 SHALL cover: aut1=aut2=aut3=1 -> nivel=3.
REQ-027 SHALL cover: three consecutive all-zero requests -> tentativas 1,2,3, bloqueado=1 for 16 cycles, req_valid ignored, then tentativas=0.
REQ-028 SHALL cover: two denials then aut1 grant -> tentativas=0, nivel=1, no lockout.
REQ-029 SHALL cover: rst_n low in cycle 4 of GRANT -> porta_aberta=0 asynchronously, IDLE after release.
REQ-030 SHALL cover: with CONTROLADOR_ACESSO_ALARME_EN, lockout -> alarme=1 persisting after LOCK exit until reset; without, alarme=0 throughout.

Source files
------------

// File: rtl/controlador_acesso_pkg.sv
`default_nettype none
// ============================================================================
// Module   : controlador_acesso_pkg
// Purpose  : FSM state encoding, grant level constants and aut priority helper
// Revision : 1.0
// ============================================================================
package controlador_acesso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DENY  = 2'd2,
        LOCK  = 2'd3
    } estado_t;

    localparam logic [1:0] NIVEL_NENHUM = 2'd0;
    localparam logic [1:0] NIVEL_AUT1   = 2'd1;
    localparam logic [1:0] NIVEL_AUT2   = 2'd2;
    localparam logic [1:0] NIVEL_AUT3   = 2'd3;

    // Highest authentication line wins when several are asserted together
    function automatic logic [1:0] resolve_nivel(input logic aut3, input logic aut2,
                                                 input logic aut1);
        if (aut3)
            return NIVEL_AUT3;
        else if (aut2)
            return NIVEL_AUT2;
        else if (aut1)
            return NIVEL_AUT1;
        else
            return NIVEL_NENHUM;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_acesso_temporizador.sv
`default_nettype none
// ============================================================================
// Module   : controlador_acesso_temporizador
// Purpose  : 8-bit loadable down-counter; done flags the last counted cycle
// Revision : 1.0
// ============================================================================
module controlador_acesso_temporizador (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       done
);

    logic [7:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_value <= 8'd0;
        else if (load)
            r_value <= load_val;
        else if (r_value != 8'd0)
            r_value <= r_value - 8'd1;
    end

    assign value = r_value;
    assign done  = (r_value == 8'd1);

endmodule
`default_nettype wire

// File: rtl/controlador_acesso.sv
`default_nettype none
// ============================================================================
// Module   : controlador_acesso
// Purpose  : Door access controller with grant timing and denial lockout.
//            Optional latched alarm: define CONTROLADOR_ACESSO_ALARME_EN.
// Revision : 1.0
// ============================================================================
module controlador_acesso
    import controlador_acesso_pkg::*;
#(
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int MAX_TRIES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       aut1,
    input  logic       aut2,
    input  logic       aut3,
    output logic       req_ready,
    output logic       porta_aberta,
    output logic [1:0] nivel,
    output logic [1:0] tentativas,
    output logic       bloqueado,
    output logic       alarme
);

    localparam logic [7:0] c_open = OPEN_CYCLES[7:0];
    localparam logic [7:0] c_lock = LOCK_CYCLES[7:0];
    localparam logic [1:0] c_max  = MAX_TRIES[1:0];

    estado_t    r_state;
    estado_t    w_state_next;
    logic [1:0] r_nivel;
    logic [1:0] r_tentativas;
    logic [1:0] w_nivel_req;
    logic       w_tmr_load;
    logic [7:0] w_tmr_val;
    logic [7:0] w_tmr_value;
    logic       w_tmr_done;
    logic       w_tmr_expired;

    assign w_nivel_req   = resolve_nivel(aut3, aut2, aut1);
    // A zero count also ends the timed state so it can never stall there
    assign w_tmr_expired = w_tmr_done || (w_tmr_value == 8'd0);

    controlador_acesso_temporizador u_temporizador (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .value    (w_tmr_value),
        .done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = c_open;
        req_ready    = 1'b0;
        porta_aberta = 1'b0;
        bloqueado    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_nivel_req != NIVEL_NENHUM) begin
                        w_state_next = GRANT;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = c_open;
                    end else begin
                        w_state_next = DENY;
                    end
                end
            end
            GRANT: begin
                porta_aberta = 1'b1;
                if (w_tmr_expired)
                    w_state_next = IDLE;
            end
            DENY: begin
                if (r_tentativas == c_max) begin
                    w_state_next = LOCK;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = c_lock;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LOCK: begin
                bloqueado = 1'b1;
                if (w_tmr_expired)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nivel      <= NIVEL_NENHUM;
            r_tentativas <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_nivel_req != NIVEL_NENHUM) begin
                            r_nivel      <= w_nivel_req;
                            r_tentativas <= 2'd0;
                        end else if (r_tentativas != 2'd3) begin
                            r_tentativas <= r_tentativas + 2'd1;
                        end
                    end
                end
                GRANT: begin
                    if (w_tmr_expired)
                        r_nivel <= NIVEL_NENHUM;
                end
                LOCK: begin
                    if (w_tmr_expired)
                        r_tentativas <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign nivel      = r_nivel;
    assign tentativas = r_tentativas;

`ifdef CONTROLADOR_ACESSO_ALARME_EN
    logic r_alarme;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_alarme <= 1'b0;
        else if ((r_state == DENY) && (w_state_next == LOCK))
            r_alarme <= 1'b1;
    end

    assign alarme = r_alarme;
`else
    assign alarme = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_controlador_acesso.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_acesso
// Purpose  : Directed and random transactions against a transaction-level model
// Revision : 1.0
// ============================================================================
module tb_controlador_acesso;

    localparam int OPEN  = 8;
    localparam int LOCKC = 16;
    localparam int MAXT  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       aut1, aut2, aut3;
    logic       req_ready;
    logic       porta_aberta;
    logic [1:0] nivel;
    logic [1:0] tentativas;
    logic       bloqueado;
    logic       alarme;

    int   total = 0;
    int   bad   = 0;
    int   t_model = 0;
    logic alarm_model = 1'b0;

    controlador_acesso #(
        .OPEN_CYCLES (OPEN),
        .LOCK_CYCLES (LOCKC),
        .MAX_TRIES   (MAXT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .aut1         (aut1),
        .aut2         (aut2),
        .aut3         (aut3),
        .req_ready    (req_ready),
        .porta_aberta (porta_aberta),
        .nivel        (nivel),
        .tentativas   (tentativas),
        .bloqueado    (bloqueado),
        .alarme       (alarme)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap(input string tag, input logic p, input logic [1:0] n,
                        input logic [1:0] t, input logic b, input logic r);
        chk({tag, ".porta"},      {7'd0, porta_aberta}, {7'd0, p});
        chk({tag, ".nivel"},      {6'd0, nivel},        {6'd0, n});
        chk({tag, ".tentativas"}, {6'd0, tentativas},   {6'd0, t});
        chk({tag, ".bloqueado"},  {7'd0, bloqueado},    {7'd0, b});
        chk({tag, ".req_ready"},  {7'd0, req_ready},    {7'd0, r});
        chk({tag, ".alarme"},     {7'd0, alarme},       {7'd0, alarm_model});
        chk({tag, ".exclusive"},  {7'd0, porta_aberta & bloqueado}, 8'd0);
    endtask

    // One request from IDLE through to the next IDLE; a = {aut3, aut2, aut1}
    task automatic do_req(input string tag, input logic [2:0] a);
        int   lvl;
        logic [1:0] t2;
        logic [1:0] l2;
        lvl = a[2] ? 3 : (a[1] ? 2 : (a[0] ? 1 : 0));
        l2  = lvl[1:0];
        t2  = t_model[1:0];
        snap({tag, ".idle"}, 1'b0, 2'd0, t2, 1'b0, 1'b1);
        req_valid = 1'b1;
        {aut3, aut2, aut1} = a;
        @(negedge clk);
        req_valid = 1'b0;
        if (lvl != 0) begin
            t_model = 0;
            for (int i = 0; i < OPEN; i++) begin
                snap({tag, ".grant"}, 1'b1, l2, 2'd0, 1'b0, 1'b0);
                {aut3, aut2, aut1} = 3'($urandom);
                @(negedge clk);
            end
        end else begin
            if (t_model < 3) t_model++;
            t2 = t_model[1:0];
            snap({tag, ".deny"}, 1'b0, 2'd0, t2, 1'b0, 1'b0);
            @(negedge clk);
            if (t_model == MAXT) begin
`ifdef CONTROLADOR_ACESSO_ALARME_EN
                alarm_model = 1'b1;
`endif
                for (int i = 0; i < LOCKC; i++) begin
                    snap({tag, ".lock"}, 1'b0, 2'd0, t2, 1'b1, 1'b0);
                    req_valid = (i != LOCKC - 1) ? 1'b1 : 1'b0;
                    {aut3, aut2, aut1} = 3'($urandom);
                    @(negedge clk);
                end
                t_model = 0;
            end
        end
        t2 = t_model[1:0];
        snap({tag, ".back"}, 1'b0, 2'd0, t2, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        t_model     = 0;
        alarm_model = 1'b0;
        chk({tag, ".porta"},      {7'd0, porta_aberta}, 8'd0);
        chk({tag, ".nivel"},      {6'd0, nivel},        8'd0);
        chk({tag, ".tentativas"}, {6'd0, tentativas},   8'd0);
        chk({tag, ".bloqueado"},  {7'd0, bloqueado},    8'd0);
        chk({tag, ".alarme"},     {7'd0, alarme},       8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        snap({tag, ".release"}, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [2:0] a;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        {aut3, aut2, aut1} = 3'b000;
        #2;
        chk("reset.porta",      {7'd0, porta_aberta}, 8'd0);
        chk("reset.nivel",      {6'd0, nivel},        8'd0);
        chk("reset.tentativas", {6'd0, tentativas},   8'd0);
        chk("reset.bloqueado",  {7'd0, bloqueado},    8'd0);
        chk("reset.alarme",     {7'd0, alarme},       8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        snap("reset.release", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);

        do_req("aut2", 3'b010);
        do_req("all_aut", 3'b111);

        // Aut lines toggling without req_valid must not start anything
        {aut3, aut2, aut1} = 3'b101;
        @(negedge clk);
        snap("no_req", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);

        do_req("deny1", 3'b000);
        do_req("deny2", 3'b000);
        do_req("deny3", 3'b000);
        @(negedge clk);
        snap("post_lock", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        do_reset("rst_after_lock");

        do_req("two_deny_a", 3'b000);
        do_req("two_deny_b", 3'b000);
        do_req("aut1_after", 3'b001);

        // Reset asserted during the fourth GRANT cycle
        req_valid = 1'b1;
        {aut3, aut2, aut1} = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            snap("mid_grant", 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
            @(negedge clk);
        end
        snap("mid_grant4", 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
        do_reset("rst_mid_grant");
        do_req("after_rst", 3'b100);

        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            do_req("rand", a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
